axi4lite_master_ctrl: RTL and testbench

- Parametrised single-outstanding AXI4-Lite master bridging a CPU-side request/response port (fetch or LSU) onto the five AXI4-Lite channels.
- Replaces the fixed-width read-then-write sequencer with:
  - a request-driven FSM;
  - concurrent AW/W issue;
  - proper B/R response capture, with the response held until the core accepts it.
- Sits between the core's memory stage and the crossbar/arbiter.

---
 rtl/axi4lite_master_ctrl_pkg.sv | 23 ++
 rtl/axi4lite_wr_issue.sv | 38 +++
 rtl/axi4lite_master_ctrl.sv | 170 +++++++++++++++++
 tb/tb_axi4lite_master_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_master_ctrl_pkg.sv
// rtl/axi4lite_master_ctrl_pkg.sv - shared widths, FSM encoding and AXI response codes
package axi4lite_master_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_RESP_WIDTH     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/axi4lite_wr_issue.sv
// rtl/axi4lite_wr_issue.sv - concurrent AW/W issue with per-channel done tracking
module axi4lite_wr_issue (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic aw_ready,
  input  logic w_ready,
  output logic aw_valid,
  output logic w_valid,
  output logic done
);

  logic aw_done;
  logic w_done;
  logic aw_fire;
  logic w_fire;

  // Valids come from the FSM state and done flags only, never from the readies.
  assign aw_valid = active && !aw_done;
  assign w_valid  = active && !w_done;
  assign aw_fire  = aw_valid && aw_ready;
  assign w_fire   = w_valid && w_ready;

  // Both channels finished, counting a handshake landing this cycle.
  assign done = active && (aw_done || aw_fire) && (w_done || w_fire);

  // Done flags remember which channel has already handshaken; cleared whenever idle.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/axi4lite_master_ctrl.sv
// rtl/axi4lite_master_ctrl.sv - single-outstanding AXI4-Lite master; watchdog under AXI4LITE_M_TIMEOUT_EN
module axi4lite_master_ctrl
  import axi4lite_master_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH     = DATA_WIDTH / 8,
  parameter int RESP_WIDTH     = DEF_RESP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iReq_valid,
  output logic                  oReq_ready,
  input  logic                  iReq_wen,
  input  logic [ADDR_WIDTH-1:0] iReq_addr,
  input  logic [DATA_WIDTH-1:0] iReq_data,
  input  logic [MASK_WIDTH-1:0] iReq_mask,
  output logic                  oRsp_valid,
  input  logic                  iRsp_ready,
  output logic [DATA_WIDTH-1:0] oRsp_data,
  output logic [RESP_WIDTH-1:0] oRsp_resp,
  input  logic                  pAXI4M_ar_ready,
  output logic                  pAXI4M_ar_valid,
  output logic [ADDR_WIDTH-1:0] pAXI4M_ar_bits_addr,
  input  logic                  pAXI4M_r_valid,
  input  logic [DATA_WIDTH-1:0] pAXI4M_r_bits_data,
  input  logic [RESP_WIDTH-1:0] pAXI4M_r_bits_resp,
  output logic                  pAXI4M_r_ready,
  input  logic                  pAXI4M_aw_ready,
  output logic                  pAXI4M_aw_valid,
  output logic [ADDR_WIDTH-1:0] pAXI4M_aw_bits_addr,
  input  logic                  pAXI4M_w_ready,
  output logic                  pAXI4M_w_valid,
  output logic [DATA_WIDTH-1:0] pAXI4M_w_bits_data,
  output logic [MASK_WIDTH-1:0] pAXI4M_w_bits_strb,
  input  logic                  pAXI4M_b_valid,
  input  logic [RESP_WIDTH-1:0] pAXI4M_b_bits_resp,
  output logic                  pAXI4M_b_ready
);

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [MASK_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [RESP_WIDTH-1:0] rsp_resp_q;

  logic req_fire;
  logic ar_fire;
  logic r_fire;
  logic b_fire;
  logic wr_done;
  logic timeout_abort;

  // All channel valids/readies are decoded from the registered state.
  assign oReq_ready      = (state == ST_IDLE);
  assign oRsp_valid      = (state == ST_RSP);
  assign pAXI4M_ar_valid = (state == ST_RD_ADDR);
  assign pAXI4M_r_ready  = (state == ST_RD_DATA);
  assign pAXI4M_b_ready  = (state == ST_WR_RESP);

  assign pAXI4M_ar_bits_addr = addr_q;
  assign pAXI4M_aw_bits_addr = addr_q;
  assign pAXI4M_w_bits_data  = data_q;
  assign pAXI4M_w_bits_strb  = mask_q;
  assign oRsp_data           = rsp_data_q;
  assign oRsp_resp           = rsp_resp_q;

  assign req_fire = iReq_valid && oReq_ready;
  assign ar_fire  = pAXI4M_ar_valid && pAXI4M_ar_ready;
  assign r_fire   = pAXI4M_r_valid && pAXI4M_r_ready;
  assign b_fire   = pAXI4M_b_valid && pAXI4M_b_ready;

  axi4lite_wr_issue u_wr_issue (
    .clk      (iClock),
    .rst      (iReset),
    .active   (state == ST_WR_REQ),
    .aw_ready (pAXI4M_aw_ready),
    .w_ready  (pAXI4M_w_ready),
    .aw_valid (pAXI4M_aw_valid),
    .w_valid  (pAXI4M_w_valid),
    .done     (wr_done)
  );

`ifdef AXI4LITE_M_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             busy;
  logic             progress;

  assign busy     = (state == ST_RD_ADDR) || (state == ST_RD_DATA) ||
                    (state == ST_WR_REQ)  || (state == ST_WR_RESP);
  assign progress = ar_fire || r_fire || wr_done || b_fire;

  // A handshake landing in the expiry cycle wins over the abort.
  assign timeout_abort = busy && !progress && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on every state change and counts only while waiting on the slave.
  always_ff @(posedge iClock) begin
    if (iReset || (state_next != state)) begin
      tmo_cnt <= '0;
    end else if (busy) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign timeout_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: one step per completed handshake, abort straight to RSP.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (req_fire)   state_next = iReq_wen ? ST_WR_REQ : ST_RD_ADDR;
      ST_RD_ADDR: if (ar_fire)    state_next = ST_RD_DATA;
      ST_RD_DATA: if (r_fire)     state_next = ST_RSP;
      ST_WR_REQ:  if (wr_done)    state_next = ST_WR_RESP;
      ST_WR_RESP: if (b_fire)     state_next = ST_RSP;
      ST_RSP:     if (iRsp_ready) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
    if (timeout_abort) begin
      state_next = ST_RSP;
    end
  end

  // Request fields are latched on acceptance so the core may change them afterwards.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else if (req_fire) begin
      addr_q <= iReq_addr;
      data_q <= iReq_data;
      mask_q <= iReq_mask;
    end
  end

  // Response capture; held unchanged through RSP until the core takes it.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rsp_data_q <= '0;
      rsp_resp_q <= RESP_WIDTH'(RESP_OKAY);
    end else if (timeout_abort) begin
      rsp_data_q <= '0;
      rsp_resp_q <= RESP_WIDTH'(RESP_SLVERR);
    end else if (r_fire) begin
      rsp_data_q <= pAXI4M_r_bits_data;
      rsp_resp_q <= pAXI4M_r_bits_resp;
    end else if (b_fire) begin
      rsp_data_q <= '0;
      rsp_resp_q <= pAXI4M_b_bits_resp;
    end
  end

endmodule

// File: tb/tb_axi4lite_master_ctrl.sv
// tb/tb_axi4lite_master_ctrl.sv - scoreboard bench with a randomized AXI4-Lite slave and memory model
module tb_axi4lite_master_ctrl;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = 4;
  localparam int RW  = 2;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid, req_ready, req_wen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [MW-1:0] req_mask;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [RW-1:0] rsp_resp;
  logic          ar_ready, ar_valid;
  logic [AW-1:0] ar_addr;
  logic          r_valid, r_ready;
  logic [DW-1:0] r_data;
  logic [RW-1:0] r_resp;
  logic          aw_ready, aw_valid;
  logic [AW-1:0] aw_addr;
  logic          w_ready, w_valid;
  logic [DW-1:0] w_data;
  logic [MW-1:0] w_strb;
  logic          b_valid, b_ready;
  logic [RW-1:0] b_resp;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axi4lite_master_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .RESP_WIDTH(RW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .iClock(clk), .iReset(rst),
    .iReq_valid(req_valid), .oReq_ready(req_ready), .iReq_wen(req_wen),
    .iReq_addr(req_addr), .iReq_data(req_data), .iReq_mask(req_mask),
    .oRsp_valid(rsp_valid), .iRsp_ready(rsp_ready), .oRsp_data(rsp_data), .oRsp_resp(rsp_resp),
    .pAXI4M_ar_ready(ar_ready), .pAXI4M_ar_valid(ar_valid), .pAXI4M_ar_bits_addr(ar_addr),
    .pAXI4M_r_valid(r_valid), .pAXI4M_r_bits_data(r_data), .pAXI4M_r_bits_resp(r_resp),
    .pAXI4M_r_ready(r_ready),
    .pAXI4M_aw_ready(aw_ready), .pAXI4M_aw_valid(aw_valid), .pAXI4M_aw_bits_addr(aw_addr),
    .pAXI4M_w_ready(w_ready), .pAXI4M_w_valid(w_valid), .pAXI4M_w_bits_data(w_data),
    .pAXI4M_w_bits_strb(w_strb),
    .pAXI4M_b_valid(b_valid), .pAXI4M_b_bits_resp(b_resp), .pAXI4M_b_ready(b_ready)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: byte-addressed words keyed by the exact request address.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];

  // Per-transaction slave behaviour, chosen by the stimulus before each request.
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0, rsp_wait = 0;
  logic [1:0] rd_resp = 2'd0, wr_resp = 2'd0;
  bit ar_block = 0, r_block = 0, lat_check = 0;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_mask;
  int accept_cyc = 0, rsp_done = 0, rsp_hold_cycles = 0, ar_hi_cycles = 0;
  int aw_fire_cyc = 0, w_fire_cyc = 0;

  // Slave state.
  bit ar_fire_p, r_fire_p, aw_fire_p, w_fire_p, b_fire_p;
  bit ar_seen, aw_seen, w_seen, rd_pend, aw_got, w_got, b_pend;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic [31:0] ar_hold, aw_hold, wd_hold, rd_addr;
  logic [3:0]  ws_hold;

  initial begin : slave
    ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
        ar_fire_p = 0; r_fire_p = 0; aw_fire_p = 0; w_fire_p = 0; b_fire_p = 0;
        ar_seen = 0; aw_seen = 0; w_seen = 0; rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
      end else begin
        // AR channel
        if (ar_fire_p) begin
          ar_fire_p = 0; ar_ready = 0; ar_seen = 0;
          check("ar_valid_drop", ar_valid, 0);
          check("ar_addr", ar_hold, exp_addr);
          rd_pend = 1; r_cnt = r_wait; rd_addr = ar_hold;
        end else if (ar_valid) begin
          ar_hi_cycles++;
          if (!ar_seen) begin
            ar_seen = 1; ar_hold = ar_addr; ar_cnt = ar_wait;
          end else begin
            check("ar_addr_stable", ar_addr, ar_hold);
          end
          if (!ar_block && ar_cnt == 0) begin ar_ready = 1; ar_fire_p = 1; end
          else if (ar_cnt > 0) ar_cnt--;
        end else begin
          if (ar_seen && !ar_block) check("ar_valid_held", ar_valid, 1);
          ar_seen = 0;
        end
        // R channel
        if (r_fire_p) begin
          r_fire_p = 0; r_valid = 0; rd_pend = 0;
          check("r_ready_drop", r_ready, 0);
        end else if (rd_pend && !r_block) begin
          if (r_cnt == 0) begin
            r_valid = 1;
            r_data = slv_mem.exists(rd_addr) ? slv_mem[rd_addr] : init_word(rd_addr);
            r_resp = rd_resp;
            if (r_ready) r_fire_p = 1;
          end else r_cnt--;
        end
        // AW channel
        if (aw_fire_p) begin
          aw_fire_p = 0; aw_ready = 0; aw_got = 1; aw_seen = 0;
          check("aw_valid_drop", aw_valid, 0);
          check("aw_addr", aw_hold, exp_addr);
        end else if (!aw_got) begin
          if (aw_valid) begin
            if (!aw_seen) begin aw_seen = 1; aw_hold = aw_addr; aw_cnt = aw_wait; end
            else check("aw_addr_stable", aw_addr, aw_hold);
            if (aw_cnt == 0) begin aw_ready = 1; aw_fire_p = 1; aw_fire_cyc = cyc; end
            else aw_cnt--;
          end else if (aw_seen) begin
            check("aw_valid_held", aw_valid, 1);
            aw_seen = 0;
          end
        end
        // W channel
        if (w_fire_p) begin
          w_fire_p = 0; w_ready = 0; w_got = 1; w_seen = 0;
          check("w_valid_drop", w_valid, 0);
          check("w_data", wd_hold, exp_wdata);
          check("w_strb", ws_hold, exp_mask);
        end else if (!w_got) begin
          if (w_valid) begin
            if (!w_seen) begin w_seen = 1; wd_hold = w_data; ws_hold = w_strb; w_cnt = w_wait; end
            else check("w_stable", {w_data, w_strb}, {wd_hold, ws_hold});
            if (w_cnt == 0) begin w_ready = 1; w_fire_p = 1; w_fire_cyc = cyc; end
            else w_cnt--;
          end else if (w_seen) begin
            check("w_valid_held", w_valid, 1);
            w_seen = 0;
          end
        end
        if (aw_got && w_got && !b_pend) begin
          slv_mem[aw_hold] = merge(slv_mem.exists(aw_hold) ? slv_mem[aw_hold] : init_word(aw_hold),
                                   wd_hold, ws_hold);
          b_pend = 1; b_cnt = b_wait;
        end
        // B channel
        if (b_fire_p) begin
          b_fire_p = 0; b_valid = 0; b_pend = 0; aw_got = 0; w_got = 0;
          check("b_ready_drop", b_ready, 0);
        end else if (b_pend) begin
          if (b_cnt == 0) begin
            b_valid = 1; b_resp = wr_resp;
            if (b_ready) b_fire_p = 1;
          end else b_cnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  bit m_seen, m_fire_p;
  int m_cnt;
  logic [31:0] m_data;
  logic [1:0]  m_resp;

  initial begin : monitor
    exp_t e;
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_ready = 0; m_seen = 0; m_fire_p = 0;
      end else if (m_fire_p) begin
        m_fire_p = 0; rsp_ready = 0; rsp_done++;
        check("rsp_valid_drop", rsp_valid, 0);
      end else if (rsp_valid) begin
        check("req_ready_while_rsp", req_ready, 0);
        if (!m_seen) begin
          m_seen = 1; m_data = rsp_data; m_resp = rsp_resp; m_cnt = rsp_wait; rsp_hold_cycles = 0;
          if (lat_check) check("read_latency", cyc - accept_cyc, 3);
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_resp", rsp_resp, e.resp);
          end
        end else begin
          check("rsp_stable", {rsp_data, rsp_resp}, {m_data, m_resp});
        end
        rsp_hold_cycles++;
        if (m_cnt == 0) begin rsp_ready = 1; m_fire_p = 1; m_seen = 0; end
        else m_cnt--;
      end
    end
  end

  // Issue one request; expected response comes from the reference model.
  task automatic do_txn(input bit wen, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input bit expect_rsp);
    int guard;
    int done0;
    exp_t e;
    guard = 0;
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!req_ready) check("req_ready_wait", 0, 1);
    exp_addr = a; exp_wdata = d; exp_mask = m;
    if (wen) begin
      ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : init_word(a), d, m);
      e.data = 32'h0; e.resp = wr_resp;
    end else begin
      e.data = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
      e.resp = rd_resp;
      if (ar_block) begin e.data = 32'h0; e.resp = 2'd2; end
    end
    if (expect_rsp) exp_q.push_back(e);
    done0 = rsp_done;
    req_valid = 1; req_wen = wen; req_addr = a; req_data = d; req_mask = m;
    accept_cyc = cyc;
    @(negedge clk);
    req_valid = 0; req_wen = $urandom_range(0, 1);
    req_addr = $urandom; req_data = $urandom; req_mask = $urandom_range(0, 15);
    if (expect_rsp) begin
      guard = 0;
      while (rsp_done == done0 && guard < 3000) begin @(negedge clk); guard++; end
      if (rsp_done == done0) check("rsp_wait", 0, 1);
    end
  endtask

  task automatic zero_waits();
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0; rsp_wait = 0;
    rd_resp = 2'd0; wr_resp = 2'd0;
  endtask

  initial begin : stim
    int guard;
    logic [31:0] a;
    req_valid = 0; req_wen = 0; req_addr = 0; req_data = 0; req_mask = 0;
    zero_waits();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {ar_valid, r_ready, aw_valid, w_valid, b_ready, rsp_valid, rsp_data, rsp_resp, ar_addr, w_data, w_strb},
          {6'b0, 32'h0, 2'b0, 32'h0, 32'h0, 4'h0});
    rst = 0;
    @(negedge clk);
    check("req_ready_after_reset", req_ready, 1);

    // Zero-wait read with latency check.
    a = 32'h8000_0004;
    ref_mem[a] = 32'hDEAD_BEEF; slv_mem[a] = 32'hDEAD_BEEF;
    lat_check = 1;
    do_txn(0, a, 32'h0, 4'h0, 1);
    lat_check = 0;

    // Write with W accepted 3 cycles ahead of AW, then read back the partial update.
    aw_wait = 3; w_wait = 0;
    do_txn(1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 1);
    check("w_before_aw_cycles", aw_fire_cyc - w_fire_cyc, 3);
    zero_waits();
    do_txn(0, 32'h8000_0010, 32'h0, 4'h0, 1);

    // Slow AR and slow response consumer.
    ar_wait = 5; rsp_wait = 4;
    do_txn(0, 32'h8000_0020, 32'h0, 4'h0, 1);
    check("rsp_hold_cycles", rsp_hold_cycles, 5);
    zero_waits();

    // DECERR write response forwarded, then a normal read.
    wr_resp = 2'd3;
    do_txn(1, 32'h8000_0008, 32'hCAFE_F00D, 4'b1111, 1);
    wr_resp = 2'd0;
    do_txn(0, 32'h8000_0008, 32'h0, 4'h0, 1);

    // Reset while waiting for R data.
    r_block = 1;
    do_txn(0, 32'h8000_0018, 32'h0, 4'h0, 0);
    guard = 0;
    while (!r_ready && guard < 50) begin @(negedge clk); guard++; end
    check("reached_rd_data", r_ready, 1);
    rst = 1;
    @(negedge clk);
    check("reset_mid_quiet", {ar_valid, r_ready, aw_valid, w_valid, b_ready, rsp_valid}, 6'b0);
    @(negedge clk);
    rst = 0; r_block = 0;
    @(negedge clk);
    check("req_ready_after_mid_reset", req_ready, 1);
    do_txn(0, 32'h8000_0004, 32'h0, 4'h0, 1);

`ifdef AXI4LITE_M_TIMEOUT_EN
    // Slave never accepts AR: watchdog aborts with SLVERR.
    ar_block = 1; ar_hi_cycles = 0;
    do_txn(0, 32'h8000_0024, 32'h0, 4'h0, 1);
    check("timeout_ar_cycles", ar_hi_cycles, TMO);
    ar_block = 0;
`endif

    // Randomized traffic over a small address pool, including unaligned addresses.
    for (int i = 0; i < 40; i++) begin
      ar_wait = $urandom_range(0, 4); r_wait = $urandom_range(0, 4);
      aw_wait = $urandom_range(0, 4); w_wait = $urandom_range(0, 4);
      b_wait = $urandom_range(0, 4); rsp_wait = $urandom_range(0, 3);
      rd_resp = 2'($urandom_range(0, 3)); wr_resp = 2'($urandom_range(0, 3));
      a = 32'h8000_0000 + 32'($urandom_range(0, 9));
      do_txn($urandom_range(0, 1), a, $urandom, 4'($urandom_range(0, 15)), 1);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

endmodule
